// File: rtl/instr_fetch_unit_mod.sv
// Instruction fetch front end: credit-limited imem requests feed a small prefetch FIFO whose
// head is shown to the control unit, with redirect/flush, misaligned-target and halt handling.
module instr_fetch_unit_mod #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [1:0]  T_o,
  output logic [2:0]  OPC_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [1:0]  pc_bits_o,
  input  logic        decode_ready_i,
  input  logic [1:0]  pc_sel_i,
  input  logic [31:0] alu_result_i,
  output logic        halted_o
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned CW1 = CW + 1;
  localparam logic [31:0]   NOP     = 32'hF800_0000;
  localparam logic [CW1-1:0] DEPTH_C = CW1'(DEPTH);
  localparam logic [1:0] SEL_SEQ  = 2'd0;
  localparam logic [1:0] SEL_REL  = 2'd1;
  localparam logic [1:0] SEL_ABS  = 2'd2;
  localparam logic [1:0] SEL_HOLD = 2'd3;

  logic [31:0]   r_fifo_instr [DEPTH];
  logic [31:0]   r_fifo_pc    [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [31:0]   r_fpc;
  logic [31:0]   r_rpc;
  logic          r_halted;
  logic          r_misalign;
  logic          r_run;

  logic          w_valid;
  logic          w_consume;
  logic          w_pop;
  logic          w_redirect;
  logic          w_halt;
  logic          w_misal;
  logic          w_credit;
  logic          w_fire;
  logic          w_keep;
  logic          w_push;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_idx;
  logic [31:0]   w_wr_data;
  logic [31:0]   w_wr_pc;
  logic [31:0]   w_head_instr;
  logic [31:0]   w_head_pc;
  logic [31:0]   w_target;
  logic [CW-1:0] w_out_next;

  // Head of queue and control-unit handshake
  assign w_head_instr = r_fifo_instr[r_rptr];
  assign w_head_pc    = r_fifo_pc[r_rptr];
  assign w_valid      = (r_count != '0);
  assign w_consume    = w_valid & decode_ready_i & ~r_halted;
  assign w_pop        = w_consume & (pc_sel_i != SEL_HOLD);
  assign w_redirect   = w_consume & ((pc_sel_i == SEL_REL) | (pc_sel_i == SEL_ABS));
  assign w_halt       = w_consume & (pc_sel_i == SEL_HOLD);
  assign w_target     = (pc_sel_i == SEL_REL) ? (w_head_pc + alu_result_i) : alu_result_i;
  assign w_misal      = (w_target[1:0] != 2'b00);

  // Request side: a request is only issued when a FIFO slot is guaranteed for its response
  assign w_credit    = ({1'b0, r_count} + {1'b0, r_outstanding}) < DEPTH_C;
  assign imem_req_o  = r_run & ~r_halted & ~r_misalign & w_credit & ~w_redirect;
  assign imem_addr_o = r_fpc;
  assign w_fire      = imem_req_o & imem_gnt_i;

  // Response side
  assign w_keep     = imem_rvalid_i & (r_drop == '0);
  assign w_push     = w_keep & ~r_halted & ~w_redirect;
  assign w_out_next = r_outstanding + CW'(w_fire) - CW'(imem_rvalid_i);

  // A misaligned redirect writes a NOP pseudo-entry into the freshly flushed slot 0
  assign w_wr_en   = w_push | (w_redirect & w_misal);
  assign w_wr_idx  = w_redirect ? '0 : r_wptr;
  assign w_wr_data = w_redirect ? NOP : imem_rdata_i;
  assign w_wr_pc   = w_redirect ? w_target : r_rpc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpc         <= RESET_PC;
      r_rpc         <= RESET_PC;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_halted      <= 1'b0;
      r_misalign    <= 1'b0;
      r_run         <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_outstanding <= w_out_next;
      if (w_fire)
        r_fpc <= r_fpc + 32'd4;
      if (w_keep)
        r_rpc <= r_rpc + 32'd4;
      if (imem_rvalid_i && (r_drop != '0))
        r_drop <= r_drop - CW'(1);
      if (w_halt)
        r_halted <= 1'b1;
      if (w_redirect) begin
        // Everything still in flight after this edge belongs to the old path
        r_fpc      <= w_target;
        r_rpc      <= w_target;
        r_drop     <= w_out_next;
        r_misalign <= w_misal;
        r_rptr     <= '0;
        r_wptr     <= w_misal ? AW'(1) : '0;
        r_count    <= w_misal ? CW'(1) : '0;
      end else begin
        r_rptr  <= r_rptr + AW'(w_pop);
        r_wptr  <= r_wptr + AW'(w_push);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_fifo_instr[w_wr_idx] <= w_wr_data;
      r_fifo_pc[w_wr_idx]    <= w_wr_pc;
    end
  end

  // Presentation to the control unit
  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? w_head_instr : NOP;
  assign pc_o          = w_valid ? w_head_pc : r_fpc;
  assign pc_plus4_o    = pc_o + 32'd4;
  assign pc_bits_o     = pc_o[1:0];
  assign T_o           = instr_o[31:30];
  assign OPC_o         = instr_o[29:27];
  assign halted_o      = r_halted;

endmodule

// File: tb/tb_instr_fetch_unit_mod.sv
// Bench for instr_fetch_unit_mod: an in-order imem model with random grant/latency and an
// architectural program-counter model that predicts every instruction the control unit sees.
module tb_instr_fetch_unit_mod;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'hF800_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [1:0]  T_o;
  logic [2:0]  OPC_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [1:0]  pc_bits_o;
  logic        decode_ready_i = 1'b0;
  logic [1:0]  pc_sel_i = 2'd0;
  logic [31:0] alu_result_i = 32'd0;
  logic        halted_o;

  instr_fetch_unit_mod #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .T_o(T_o), .OPC_o(OPC_o),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .pc_bits_o(pc_bits_o),
    .decode_ready_i(decode_ready_i), .pc_sel_i(pc_sel_i), .alu_result_i(alu_result_i),
    .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_consume = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] acc_log[$];
  logic [31:0] m_pc = RESET_PC;
  logic        last_req = 1'b0;
  logic        gnt_rand = 1'b0;
  int          lat_min = 1;
  int          lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Architectural model: the head shown at a consume must be the next PC of program flow
  task automatic sb_consume(input logic [1:0] sel, input logic [31:0] alu);
    logic [31:0] exp_i;
    exp_i = (m_pc[1:0] != 2'b00) ? NOP : mem_word(m_pc);
    chk("sb_pc", pc_o, m_pc);
    chk("sb_instr", instr_o, exp_i);
    chk("sb_pc4", pc_plus4_o, m_pc + 32'd4);
    chk("sb_fields", {25'd0, T_o, OPC_o, pc_bits_o}, {25'd0, exp_i[31:27], m_pc[1:0]});
    case (sel)
      2'd0: m_pc = m_pc + 32'd4;
      2'd1: m_pc = m_pc + alu;
      2'd2: m_pc = alu;
      default: ;
    endcase
  endtask

  task automatic step(input logic rdy, input logic [1:0] sel, input logic [31:0] alu);
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    imem_gnt_i     = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    decode_ready_i = rdy;
    pc_sel_i       = sel;
    alu_result_i   = alu;
    #1;
    last_req = imem_req_o;
    if (imem_req_o && imem_gnt_i) begin
      chk("addr_align", {30'd0, imem_addr_o[1:0]}, 32'd0);
      acc_log.push_back(imem_addr_o);
      pend_addr.push_back(imem_addr_o);
      pend_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
    end
    if (instr_valid_o && decode_ready_i && !halted_o) begin
      n_consume++;
      sb_consume(sel, alu);
    end
    chk("credits", (pend_addr.size() <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_pc", pc_o, RESET_PC);
    chk("rst_req", imem_req_o, 0);
    chk("rst_halted", halted_o, 0);
    pend_addr.delete();
    pend_due.delete();
    acc_log.delete();
    imem_rvalid_i = 1'b0;
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #1;
    rst_n = 1'b1;
    m_pc  = RESET_PC;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int reqs;
    int r;
    logic rdy;
    logic [1:0] sel;
    logic [31:0] alu;

    @(posedge clk); #1;

    // 1: reset state, then fill four credits with the control unit stalled
    do_reset();
    repeat (12) step(1'b0, 2'd0, 32'd0);
    chk("t1_nreq", acc_log.size(), 4);
    for (int i = 0; i < acc_log.size(); i++)
      chk("t1_addr", acc_log[i], RESET_PC + 32'(i * 4));
    chk("t1_valid", instr_valid_o, 1);
    chk("t1_pc", pc_o, RESET_PC);
    chk("t1_instr", instr_o, mem_word(RESET_PC));

    // 2: sequential stream, one consume per cycle
    n_consume = 0;
    repeat (40) step(1'b1, 2'd0, 32'd0);
    chk("t2_consumed", n_consume, 40);

    // 3: relative branch at pc 0x10 drops in-flight words
    lat_min = 3; lat_max = 3;
    step(1'b1, 2'd2, 32'h0);
    for (int k = 0; k < 60 && !(instr_valid_o && pc_o == 32'h10); k++) step(1'b1, 2'd0, 32'd0);
    chk("t3_reach", pc_o, 32'h10);
    acc_log.delete();
    step(1'b1, 2'd1, 32'h20);
    chk("t3_redir_noreq", last_req, 0);
    for (int k = 0; k < 30 && !instr_valid_o; k++) step(1'b0, 2'd0, 32'd0);
    chk("t3_valid", instr_valid_o, 1);
    chk("t3_pc", pc_o, 32'h30);
    chk("t3_instr", instr_o, mem_word(32'h30));
    chk("t3_first_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, 32'h30);

    // 4: misaligned absolute target, then halt
    acc_log.delete();
    step(1'b1, 2'd2, 32'h102);
    for (int k = 0; k < 10 && !instr_valid_o; k++) step(1'b0, 2'd0, 32'd0);
    chk("t4_valid", instr_valid_o, 1);
    chk("t4_pc", pc_o, 32'h102);
    chk("t4_pc_bits", pc_bits_o, 2);
    chk("t4_T", T_o, 3);
    chk("t4_OPC", OPC_o, 7);
    chk("t4_instr", instr_o, NOP);
    repeat (8) step(1'b0, 2'd0, 32'd0);
    chk("t4_noreq", acc_log.size(), 0);
    step(1'b1, 2'd3, 32'd0);
    chk("t4_halted", halted_o, 1);
    reqs = 0;
    repeat (20) begin
      step(1'b1, 2'd0, 32'd0);
      reqs += int'(last_req);
    end
    chk("t4_halt_noreq", reqs, 0);
    chk("t4_hold_pc", pc_o, 32'h102);
    chk("t4_hold_valid", instr_valid_o, 1);

    // 5: random grant, latency, ready and redirects (including across the address wrap)
    do_reset();
    gnt_rand = 1'b1; lat_min = 1; lat_max = 5;
    n_consume = 0;
    for (int k = 0; k < 2000; k++) begin
      r   = int'($urandom_range(0, 99));
      rdy = ($urandom_range(0, 3) != 0);
      sel = 2'd0;
      alu = $urandom;
      if (r >= 80 && r < 90) begin
        sel = 2'd1;
        alu = 32'($urandom_range(0, 16)) * 32'd4 - 32'd32;
      end else if (r >= 90) begin
        sel = 2'd2;
        alu = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : 32'h100 + 32'($urandom_range(0, 63)) * 32'd4;
      end
      step(rdy, sel, alu);
    end
    chk("t5_progress", (n_consume > 200) ? 32'd1 : 32'd0, 32'd1);

    // 6: reset in the middle of a burst, fetch restarts at RESET_PC
    repeat (30) step(1'($urandom_range(0, 1)), 2'd0, 32'd0);
    do_reset();
    gnt_rand = 1'b0; lat_min = 1; lat_max = 1;
    repeat (10) step(1'b0, 2'd0, 32'd0);
    chk("t6_first_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, RESET_PC);
    chk("t6_valid", instr_valid_o, 1);
    chk("t6_pc", pc_o, RESET_PC);
    n_consume = 0;
    repeat (20) step(1'b1, 2'd0, 32'd0);
    chk("t6_consumed", n_consume, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
